// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - quadrature phase type, Gray-code phase constants and forward successor.
package qdec_pkg;

  typedef logic [1:0] qphase_t;

  localparam qphase_t PH_00 = 2'b00;
  localparam qphase_t PH_01 = 2'b01;
  localparam qphase_t PH_11 = 2'b11;
  localparam qphase_t PH_10 = 2'b10;

  function automatic qphase_t qdec_next(input qphase_t prev);
    case (prev)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - quadrature pins in, step/dir/err/err_cnt out; master drives pins, slave is the decoder.
interface quad_decoder_if #(
  parameter int ERR_CNT_W = 8
);

  logic                 a_in;
  logic                 b_in;
  logic                 clr_err;
  logic                 step;
  logic                 dir;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (output a_in, b_in, clr_err, input step, dir, err, err_cnt);
  modport slave  (input a_in, b_in, clr_err, output step, dir, err, err_cnt);

endinterface

// File: rtl/quad_decoder_chan_cond.sv
// rtl/quad_decoder_chan_cond.sv - per-phase synchroniser plus glitch filter when QDEC_GLITCH_FILTER_EN is defined.
module qdec_chan_cond #(
  parameter int SYNC_STAGES = 2
`ifdef QDEC_GLITCH_FILTER_EN
  ,
  parameter int FILT_LEN    = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic ph,
  output logic valid
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] arm_q, arm_d;
  logic                   sync_out;

  // arm_q marches ones alongside the data so valid rises once reset zeros are flushed
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    arm_d  = {arm_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      arm_q  <= arm_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign valid    = arm_q[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int             CNT_W   = $clog2(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  logic             filt_q, filt_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The current sample counts toward the run, so the output moves on the FILT_LEN-th equal sample
  always_comb begin
    filt_d   = filt_q;
    cnt_d    = cnt_q;
    primed_d = primed_q | valid;
    if (!primed_q) begin
      filt_d = sync_out;
      cnt_d  = '0;
    end else if (sync_out == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      filt_d = sync_out;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      filt_q   <= filt_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ph = filt_d;
`else
  assign ph = sync_out;
`endif

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder: step/dir pulses, illegal-transition err and saturating err_cnt.
// Optional glitch filter on each phase is enabled by defining QDEC_GLITCH_FILTER_EN.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  quad_decoder_if.slave  qif
);

  import qdec_pkg::*;

  if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_params
    $error("quad_decoder: SYNC_STAGES and FILT_LEN must be at least 2");
  end

  logic a_ph, b_ph, a_valid, b_valid, cond_valid;

  qdec_chan_cond #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    ,
    .FILT_LEN(FILT_LEN)
`endif
  ) u_cond_a (
    .clk  (clk),
    .rst  (rst),
    .pin  (qif.a_in),
    .ph   (a_ph),
    .valid(a_valid)
  );

  qdec_chan_cond #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    ,
    .FILT_LEN(FILT_LEN)
`endif
  ) u_cond_b (
    .clk  (clk),
    .rst  (rst),
    .pin  (qif.b_in),
    .ph   (b_ph),
    .valid(b_valid)
  );

  qphase_t              ab_s;
  qphase_t              prev_ab_q, prev_ab_d;
  logic                 init_done_q, init_done_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign ab_s       = {a_ph, b_ph};
  assign cond_valid = a_valid & b_valid;

  // The init cycle waits for the conditioners to flush their reset zeros, so a pin
  // level already present at reset release is never mistaken for an edge.
  always_comb begin
    prev_ab_d   = prev_ab_q;
    init_done_d = init_done_q;
    step_d      = 1'b0;
    dir_d       = dir_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (cond_valid) begin
      prev_ab_d   = ab_s;
      init_done_d = 1'b1;
      if (init_done_q) begin
        if (ab_s == qdec_next(prev_ab_q)) begin
          step_d = 1'b1;
          dir_d  = 1'b0;
        end else if (qdec_next(ab_s) == prev_ab_q) begin
          step_d = 1'b1;
          dir_d  = 1'b1;
        end else if (ab_s != prev_ab_q) begin
          err_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
      end
    end
    if (qif.clr_err) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_q   <= PH_00;
      init_done_q <= 1'b0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      prev_ab_q   <= prev_ab_d;
      init_done_q <= init_done_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign qif.step    = step_q;
  assign qif.dir     = dir_q;
  assign qif.err     = err_q;
  assign qif.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed and random checks of quad_decoder against a Gray-position reference model.
module tb_quad_decoder;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int CW   = 8;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT  = SYNC + FILT;
`else
  localparam int LAT  = SYNC + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_decoder_if #(.ERR_CNT_W(CW)) qif ();

  quad_decoder #(
    .SYNC_STAGES(SYNC),
    .FILT_LEN   (FILT),
    .ERR_CNT_W  (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .qif(qif)
  );

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  m_ab;
  logic        m_dir;
  int          m_cnt;
  int          fed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic move(input logic [1:0] ab, input int hold, input bit clr, input string tag);
    int d, n_step, n_err, first;
    bit exp_step, exp_err;
    d        = (gpos(ab) - gpos(m_ab) + 4) % 4;
    exp_step = (d == 1) || (d == 3);
    exp_err  = (d == 2);
    if (d == 1) m_dir = 1'b0;
    else if (d == 3) m_dir = 1'b1;
    if (exp_err && m_cnt < (1 << CW) - 1) m_cnt++;
    if (clr) m_cnt = 0;
    m_ab = ab;
    qif.a_in = ab[1];
    qif.b_in = ab[0];
    n_step = 0;
    n_err  = 0;
    first  = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (qif.step) begin
        n_step++;
        fed += qif.dir ? -1 : 1;
        if (first == 0) first = i;
      end
      if (qif.err) begin
        n_err++;
        if (first == 0) first = i;
      end
      qif.clr_err = clr && (i == LAT - 1);
    end
    qif.clr_err = 1'b0;
    check({tag, " step"}, n_step, {31'd0, exp_step});
    check({tag, " err"}, n_err, {31'd0, exp_err});
    check({tag, " dir"}, {31'd0, qif.dir}, {31'd0, m_dir});
    check({tag, " err_cnt"}, {24'd0, qif.err_cnt}, m_cnt);
    if (exp_step || exp_err) check({tag, " latency"}, first, LAT);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int n_step, n_err;
    n_step = 0;
    n_err  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (qif.step) n_step++;
      if (qif.err)  n_err++;
    end
    check({tag, " no step"}, n_step, 0);
    check({tag, " no err"}, n_err, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " step"}, {31'd0, qif.step}, 0);
    check({tag, " dir"}, {31'd0, qif.dir}, 0);
    check({tag, " err"}, {31'd0, qif.err}, 0);
    check({tag, " err_cnt"}, {24'd0, qif.err_cnt}, 0);
  endtask

  initial begin
    rst         = 1'b1;
    qif.a_in    = 1'b1;
    qif.b_in    = 1'b1;
    qif.clr_err = 1'b0;
    fed         = 0;
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst = 1'b0;
    quiet(10, "release_11");
    check_zero("after_release");
    m_ab  = 2'b11;
    m_dir = 1'b0;
    m_cnt = 0;

    move(2'b10, 8, 1'b0, "walk_10");
    move(2'b00, 8, 1'b0, "walk_00");

    fed = 0;
    move(2'b01, 8, 1'b0, "fwd_01");
    move(2'b11, 8, 1'b0, "fwd_11");
    move(2'b10, 8, 1'b0, "fwd_10");
    move(2'b00, 8, 1'b0, "fwd_00");
    check("fwd counter", fed, 4);

    move(2'b10, 8, 1'b0, "rev_10");
    move(2'b11, 8, 1'b0, "rev_11");
    move(2'b01, 8, 1'b0, "rev_01");
    move(2'b00, 8, 1'b0, "rev_00");
    check("rev counter", fed, 0);

    for (int n = 0; n < 300; n++) begin
      move((m_ab == 2'b00) ? 2'b11 : 2'b00, LAT + 2, 1'b0, "jump");
    end
    check("saturated err_cnt", {24'd0, qif.err_cnt}, 255);

    move(2'b11, LAT + 3, 1'b1, "clr_with_err");
    move(2'b00, LAT + 3, 1'b0, "err_after_clr");
    move(2'b10, LAT + 3, 1'b0, "rev_before_rst");

    qif.a_in = 1'b1;
    qif.b_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("mid_reset");
    qif.a_in = 1'b0;
    qif.b_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    quiet(20, "release_01");
    check_zero("after_mid_reset");
    m_ab  = 2'b01;
    m_dir = 1'b0;
    m_cnt = 0;

    for (int n = 0; n < 40; n++) begin
      move(2'($urandom_range(0, 3)), LAT + 2 + $urandom_range(0, 4),
           ($urandom_range(0, 7) == 0), "random");
    end

`ifdef QDEC_GLITCH_FILTER_EN
    qif.a_in = ~m_ab[1];
    repeat (3) @(negedge clk);
    qif.a_in = m_ab[1];
    quiet(15, "glitch_3");
    move(m_ab ^ 2'b10, LAT + 4, 1'b0, "stable_edge");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
